// File: rtl/decode_issue_if.sv
// rtl/decode_issue_if.sv - fetch-to-decode instruction handshake
//   inst       : 32-bit instruction word
//   inst_valid : fetch presents inst
//   inst_ready : decode accepts inst this cycle
interface decode_issue_if;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;

  modport master (output inst, inst_valid, input inst_ready);
  modport slave  (input inst, inst_valid, output inst_ready);
endinterface

// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - decode/issue stage between instruction fetch and execute
//   clk, rst (async, active-low)
//   fetch             : instruction handshake (slave side)
//   rf_raddr1/2/3     : combinational register file read addresses (rs1, rs2, rd)
//   rf_rdata1/2/3     : same-cycle register file read data
//   do_branch         : execute reports a taken branch
//   is_* / val1..3    : registered one-hot ALU select, controls and operands
//   is_*_data_hazard  : registered forwarding selects against the previous issue
module decode_issue #(
  parameter int WORD_W = 16,
  parameter int REG_N  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  decode_issue_if.slave              fetch,
  output logic [$clog2(REG_N)-1:0]   rf_raddr1,
  output logic [$clog2(REG_N)-1:0]   rf_raddr2,
  output logic [$clog2(REG_N)-1:0]   rf_raddr3,
  input  logic [WORD_W-1:0]          rf_rdata1,
  input  logic [WORD_W-1:0]          rf_rdata2,
  input  logic [WORD_W-1:0]          rf_rdata3,
  input  logic                       do_branch,
  output logic                       is_add,
  output logic                       is_sub,
  output logic                       is_and,
  output logic                       is_or,
  output logic                       is_gt,
  output logic                       is_eq,
  output logic                       is_mem_write,
  output logic                       is_reg_write,
  output logic                       is_halt,
  output logic                       is_branch,
  output logic [WORD_W-1:0]          val1,
  output logic [WORD_W-1:0]          val2,
  output logic [WORD_W-1:0]          val3,
  output logic                       is_val1_data_hazard,
  output logic                       is_val2_data_hazard,
  output logic                       is_mem_data_hazard
);
  localparam int RA_W = $clog2(REG_N);

  localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3, OP_OR   = 4'h4;
  localparam logic [3:0] OP_GT  = 4'h5, OP_EQ  = 4'h6, OP_ADDI = 4'h7, OP_LOAD = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9, OP_BEQ = 4'hA, OP_BGT = 4'hB, OP_HALT = 4'hF;

  localparam logic [1:0] S_RUN = 2'd0, S_STALL = 2'd1, S_HALTED = 2'd2;

  // ALU select bit order: {add, sub, and, or, gt, eq}
  localparam logic [5:0] ALU_ADD = 6'b100000, ALU_SUB = 6'b010000, ALU_AND = 6'b001000;
  localparam logic [5:0] ALU_OR  = 6'b000100, ALU_GT  = 6'b000010, ALU_EQ  = 6'b000001;

  logic [1:0]        state;
  logic [3:0]        op;
  logic [RA_W-1:0]   rd, rs1, rs2;
  logic [15:0]       imm;
  logic [WORD_W-1:0] imm_w, rd_w;

  logic [5:0]        d_alu;
  logic              d_mw, d_wr, d_halt, d_br, d_load, use_rs1, use_rs2;
  logic [WORD_W-1:0] d_v1, d_v2, d_v3;

  logic [RA_W-1:0]   prev_dst;
  logic              prev_wr, prev_load;
  logic              haz1, haz2, store_hazard, stall_req, accept;

  logic [5:0]        alu_q;
  logic              mw_q, wr_q, halt_q, br_q;
  logic [WORD_W-1:0] v1_q, v2_q, v3_q;
  logic              haz1_q, haz2_q, hazm_q;

  assign op    = fetch.inst[31:28];
  assign rd    = fetch.inst[24 +: RA_W];
  assign rs1   = fetch.inst[20 +: RA_W];
  assign rs2   = fetch.inst[16 +: RA_W];
  assign imm   = fetch.inst[15:0];
  assign imm_w = WORD_W'($signed(imm));
  assign rd_w  = WORD_W'(rd);

  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;
  assign rf_raddr3 = rd;

  always_comb begin
    d_alu   = '0;
    d_mw    = 1'b0;
    d_wr    = 1'b0;
    d_halt  = 1'b0;
    d_br    = 1'b0;
    d_load  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    d_v1    = '0;
    d_v2    = '0;
    d_v3    = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_GT, OP_EQ: begin
        case (op)
          OP_ADD:  d_alu = ALU_ADD;
          OP_SUB:  d_alu = ALU_SUB;
          OP_AND:  d_alu = ALU_AND;
          OP_OR:   d_alu = ALU_OR;
          OP_GT:   d_alu = ALU_GT;
          default: d_alu = ALU_EQ;
        endcase
        d_v1    = rf_rdata1;
        d_v2    = rf_rdata2;
        d_v3    = rd_w;
        d_wr    = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_ADDI, OP_LOAD: begin
        d_alu   = ALU_ADD;
        d_v1    = rf_rdata1;
        d_v2    = imm_w;
        d_v3    = rd_w;
        d_wr    = 1'b1;
        d_load  = (op == OP_LOAD);
        use_rs1 = 1'b1;
      end
      OP_STORE: begin
        // address = val1 + val2, store data travels in val3
        d_alu   = ALU_ADD;
        d_v1    = rf_rdata1;
        d_v2    = imm_w;
        d_v3    = rf_rdata3;
        d_mw    = 1'b1;
        use_rs1 = 1'b1;
      end
      OP_BEQ, OP_BGT: begin
        d_alu   = (op == OP_BEQ) ? ALU_EQ : ALU_GT;
        d_v1    = rf_rdata1;
        d_v2    = rf_rdata2;
        d_v3    = imm_w;
        d_br    = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_HALT: d_halt = 1'b1;
      default: ;
    endcase
  end

  assign haz1 = use_rs1 && prev_wr && (rs1 == prev_dst);
  assign haz2 = use_rs2 && prev_wr && (rs2 == prev_dst);

  // Store data (rd) comes straight from the register file with no forwarding
  // path, so a store right behind its producer waits one bubble.
  assign store_hazard = (op == OP_STORE) && prev_wr && (rd == prev_dst);
  assign stall_req    = (state != S_HALTED) && !do_branch && fetch.inst_valid && store_hazard;

  assign fetch.inst_ready = rst && (state != S_HALTED) && !do_branch
                            && !(fetch.inst_valid && store_hazard);
  assign accept = fetch.inst_valid && fetch.inst_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_RUN;
      alu_q     <= '0;
      mw_q      <= 1'b0;
      wr_q      <= 1'b0;
      halt_q    <= 1'b0;
      br_q      <= 1'b0;
      v1_q      <= '0;
      v2_q      <= '0;
      v3_q      <= '0;
      haz1_q    <= 1'b0;
      haz2_q    <= 1'b0;
      hazm_q    <= 1'b0;
      prev_dst  <= '0;
      prev_wr   <= 1'b0;
      prev_load <= 1'b0;
    end else begin
      if (state != S_HALTED) begin
        if (accept && op == OP_HALT) state <= S_HALTED;
        else if (stall_req)          state <= S_STALL;
        else                         state <= S_RUN;
      end

      // Bubble by default; an accepted instruction overrides below.
      alu_q     <= '0;
      mw_q      <= 1'b0;
      wr_q      <= 1'b0;
      halt_q    <= 1'b0;
      br_q      <= 1'b0;
      v1_q      <= '0;
      v2_q      <= '0;
      v3_q      <= '0;
      haz1_q    <= 1'b0;
      haz2_q    <= 1'b0;
      hazm_q    <= 1'b0;
      prev_wr   <= 1'b0;
      prev_load <= 1'b0;

      if (state == S_HALTED) begin
        halt_q <= 1'b1;
      end else if (accept) begin
        alu_q     <= d_alu;
        mw_q      <= d_mw;
        wr_q      <= d_wr;
        halt_q    <= d_halt;
        br_q      <= d_br;
        v1_q      <= d_v1;
        v2_q      <= d_v2;
        v3_q      <= d_v3;
        haz1_q    <= haz1;
        haz2_q    <= haz2;
        hazm_q    <= prev_load && (haz1 || haz2);
        prev_dst  <= rd;
        prev_wr   <= d_wr;
        prev_load <= d_load;
      end
    end
  end

  assign {is_add, is_sub, is_and, is_or, is_gt, is_eq} = alu_q;

  // A taken branch kills whatever execute is sampling this cycle.
  assign is_mem_write = mw_q   && !do_branch;
  assign is_reg_write = wr_q   && !do_branch;
  assign is_halt      = halt_q && !do_branch;
  assign is_branch    = br_q   && !do_branch;

  assign val1 = v1_q;
  assign val2 = v2_q;
  assign val3 = v3_q;
  assign is_val1_data_hazard = haz1_q;
  assign is_val2_data_hazard = haz2_q;
  assign is_mem_data_hazard  = hazm_q;
endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - scoreboard bench for decode_issue
module tb_decode_issue;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  ra1, ra2, ra3;
  logic [15:0] rd1, rd2, rd3;
  logic        do_branch;
  logic        is_add, is_sub, is_and, is_or, is_gt, is_eq;
  logic        is_mem_write, is_reg_write, is_halt, is_branch;
  logic [15:0] val1, val2, val3;
  logic        h1, h2, hm;
  logic [15:0] rf [16];

  decode_issue_if fetch ();

  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];
  assign rd3 = rf[ra3];

  decode_issue #(.WORD_W(16), .REG_N(16)) dut (
    .clk(clk), .rst(rst), .fetch(fetch),
    .rf_raddr1(ra1), .rf_raddr2(ra2), .rf_raddr3(ra3),
    .rf_rdata1(rd1), .rf_rdata2(rd2), .rf_rdata3(rd3),
    .do_branch(do_branch),
    .is_add(is_add), .is_sub(is_sub), .is_and(is_and), .is_or(is_or),
    .is_gt(is_gt), .is_eq(is_eq),
    .is_mem_write(is_mem_write), .is_reg_write(is_reg_write),
    .is_halt(is_halt), .is_branch(is_branch),
    .val1(val1), .val2(val2), .val3(val3),
    .is_val1_data_hazard(h1), .is_val2_data_hazard(h2), .is_mem_data_hazard(hm)
  );

  // ctl bit order: {add, sub, and, or, gt, eq, mem_write, reg_write, halt, branch}
  typedef struct packed {
    logic [9:0]  ctl;
    logic [15:0] v1;
    logic [15:0] v2;
    logic [15:0] v3;
    logic [2:0]  haz;
  } out_t;

  localparam logic [9:0] C_ADD = 10'h200, C_SUB = 10'h100, C_AND = 10'h080, C_OR = 10'h040;
  localparam logic [9:0] C_GT  = 10'h020, C_EQ  = 10'h010, C_MW  = 10'h008, C_RW = 10'h004;
  localparam logic [9:0] C_HALT = 10'h002, C_BR = 10'h001;

  out_t exp_q [$];
  int   total  = 0;
  int   passed = 0;

  function automatic out_t mk(logic [9:0] c, logic [15:0] a, logic [15:0] b, logic [15:0] d,
                              logic [2:0] h);
    return {c, a, b, d, h};
  endfunction

  function automatic logic [31:0] ins(logic [3:0] op, logic [3:0] rd, logic [3:0] rs1,
                                      logic [3:0] rs2, logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  function automatic out_t sample();
    return {is_add, is_sub, is_and, is_or, is_gt, is_eq, is_mem_write, is_reg_write,
            is_halt, is_branch, val1, val2, val3, h1, h2, hm};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [31:0] i, logic v, logic b);
    fetch.inst       = i;
    fetch.inst_valid = v;
    do_branch        = b;
  endtask

  task automatic test_reset();
    out_t obs, e;
    rst = 1'b0;
    drive(32'h0, 1'b0, 1'b0);
    repeat (2) cyc();
    obs = sample();
    total++;
    if (obs !== '0) $display("FAIL reset_outputs got %h expected 0", obs);
    else passed++;
    total++;
    if (fetch.inst_ready !== 1'b0) $display("FAIL reset_ready_low got %b expected 0", fetch.inst_ready);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if (fetch.inst_ready !== 1'b1) $display("FAIL reset_ready_release got %b expected 1", fetch.inst_ready);
    else passed++;
    exp_q.push_back('0);
    cyc();
    obs = sample();
    e = exp_q.pop_front();
    total++;
    if (obs !== e) $display("FAIL reset_first_edge got %h expected %h", obs, e);
    else passed++;
  endtask

  task automatic test_add();
    out_t obs, e;
    logic [31:0] ti [2];
    logic        tv [2];
    out_t        te [2];
    ti = '{ins(4'h1, 4'd3, 4'd1, 4'd2, 16'h0), 32'h0};
    tv = '{1'b1, 1'b0};
    te = '{mk(C_ADD | C_RW, 16'd5, 16'd7, 16'd3, 3'b000), '0};
    for (int i = 0; i < 2; i++) begin
      drive(ti[i], tv[i], 1'b0);
      exp_q.push_back(te[i]);
      cyc();
      obs = sample();
      e = exp_q.pop_front();
      total++;
      if (obs !== e) $display("FAIL add[%0d] got %h expected %h", i, obs, e);
      else passed++;
    end
  endtask

  task automatic test_hazard();
    out_t obs, e;
    logic [31:0] ti [11];
    out_t        te [11];
    ti = '{ins(4'h1, 4'd3,  4'd1,  4'd2,  16'h0),
           ins(4'h2, 4'd4,  4'd3,  4'd3,  16'h0),
           ins(4'h8, 4'd3,  4'd1,  4'd0,  16'h4),
           ins(4'h2, 4'd4,  4'd3,  4'd3,  16'h0),
           ins(4'h7, 4'd7,  4'd1,  4'd4,  16'hFFFE),
           ins(4'h7, 4'd8,  4'd7,  4'd0,  16'h1),
           ins(4'h3, 4'd9,  4'd1,  4'd2,  16'h0),
           ins(4'h4, 4'd10, 4'd9,  4'd2,  16'h0),
           ins(4'h5, 4'd11, 4'd2,  4'd10, 16'h0),
           ins(4'h6, 4'd12, 4'd1,  4'd1,  16'h0),
           32'h0};
    te = '{mk(C_ADD | C_RW, 16'd5,     16'd7,     16'd3,  3'b000),
           mk(C_SUB | C_RW, 16'h103,   16'h103,   16'd4,  3'b110),
           mk(C_ADD | C_RW, 16'd5,     16'd4,     16'd3,  3'b000),
           mk(C_SUB | C_RW, 16'h103,   16'h103,   16'd4,  3'b111),
           mk(C_ADD | C_RW, 16'd5,     16'hFFFE,  16'd7,  3'b000),
           mk(C_ADD | C_RW, 16'h107,   16'd1,     16'd8,  3'b100),
           mk(C_AND | C_RW, 16'd5,     16'd7,     16'd9,  3'b000),
           mk(C_OR  | C_RW, 16'h109,   16'd7,     16'd10, 3'b100),
           mk(C_GT  | C_RW, 16'd7,     16'h10A,   16'd11, 3'b010),
           mk(C_EQ  | C_RW, 16'd5,     16'd5,     16'd12, 3'b000),
           '0};
    for (int i = 0; i < 11; i++) begin
      drive(ti[i], (i < 10), 1'b0);
      exp_q.push_back(te[i]);
      cyc();
      obs = sample();
      e = exp_q.pop_front();
      total++;
      if (obs !== e) $display("FAIL hazard[%0d] got %h expected %h", i, obs, e);
      else passed++;
    end
  endtask

  task automatic test_store_stall();
    out_t obs, e;
    logic [31:0] st;
    st = ins(4'h9, 4'd5, 4'd1, 4'd0, 16'h8);
    drive(ins(4'h7, 4'd5, 4'd1, 4'd0, 16'h2), 1'b1, 1'b0);
    exp_q.push_back(mk(C_ADD | C_RW, 16'd5, 16'd2, 16'd5, 3'b000));
    cyc();
    obs = sample(); e = exp_q.pop_front(); total++;
    if (obs !== e) $display("FAIL store_producer got %h expected %h", obs, e);
    else passed++;
    drive(st, 1'b1, 1'b0);
    #1;
    total++;
    if (fetch.inst_ready !== 1'b0) $display("FAIL store_stall_ready got %b expected 0", fetch.inst_ready);
    else passed++;
    exp_q.push_back('0);
    cyc();
    obs = sample(); e = exp_q.pop_front(); total++;
    if (obs !== e) $display("FAIL store_bubble got %h expected %h", obs, e);
    else passed++;
    #1;
    total++;
    if (fetch.inst_ready !== 1'b1) $display("FAIL store_retry_ready got %b expected 1", fetch.inst_ready);
    else passed++;
    exp_q.push_back(mk(C_ADD | C_MW, 16'd5, 16'd8, 16'h105, 3'b000));
    cyc();
    obs = sample(); e = exp_q.pop_front(); total++;
    if (obs !== e) $display("FAIL store_issue got %h expected %h", obs, e);
    else passed++;
    drive(32'h0, 1'b0, 1'b0);
    #1;
    total++;
    if (fetch.inst_ready !== 1'b1) $display("FAIL store_no_repeat_ready got %b expected 1", fetch.inst_ready);
    else passed++;
    exp_q.push_back('0);
    cyc();
    obs = sample(); e = exp_q.pop_front(); total++;
    if (obs !== e) $display("FAIL store_after got %h expected %h", obs, e);
    else passed++;
  endtask

  task automatic test_branch();
    out_t obs, e;
    logic [31:0] add10;
    add10 = ins(4'h1, 4'd10, 4'd9, 4'd9, 16'h0);
    drive(ins(4'hA, 4'd0, 4'd1, 4'd2, 16'h0040), 1'b1, 1'b0);
    exp_q.push_back(mk(C_EQ | C_BR, 16'd5, 16'd7, 16'h40, 3'b000));
    cyc();
    obs = sample(); e = exp_q.pop_front(); total++;
    if (obs !== e) $display("FAIL beq_issue got %h expected %h", obs, e);
    else passed++;
    drive(ins(4'h1, 4'd9, 4'd1, 4'd2, 16'h0), 1'b1, 1'b0);
    exp_q.push_back(mk(C_ADD | C_RW, 16'd5, 16'd7, 16'd9, 3'b000));
    cyc();
    obs = sample(); e = exp_q.pop_front(); total++;
    if (obs !== e) $display("FAIL prebranch_add got %h expected %h", obs, e);
    else passed++;
    drive(add10, 1'b1, 1'b1);
    #1;
    obs = sample(); e = mk(C_ADD, 16'd5, 16'd7, 16'd9, 3'b000); total++;
    if (obs !== e) $display("FAIL squash_comb got %h expected %h", obs, e);
    else passed++;
    total++;
    if (fetch.inst_ready !== 1'b0) $display("FAIL squash_ready got %b expected 0", fetch.inst_ready);
    else passed++;
    exp_q.push_back('0);
    cyc();
    obs = sample(); e = exp_q.pop_front(); total++;
    if (obs !== e) $display("FAIL squash_bubble got %h expected %h", obs, e);
    else passed++;
    drive(add10, 1'b1, 1'b0);
    exp_q.push_back(mk(C_ADD | C_RW, 16'h109, 16'h109, 16'd10, 3'b000));
    cyc();
    obs = sample(); e = exp_q.pop_front(); total++;
    if (obs !== e) $display("FAIL redirect_add got %h expected %h", obs, e);
    else passed++;
    drive(ins(4'hB, 4'd0, 4'd10, 4'd2, 16'h0080), 1'b1, 1'b0);
    exp_q.push_back(mk(C_GT | C_BR, 16'h10A, 16'd7, 16'h80, 3'b100));
    cyc();
    obs = sample(); e = exp_q.pop_front(); total++;
    if (obs !== e) $display("FAIL bgt_issue got %h expected %h", obs, e);
    else passed++;
    drive(32'h0, 1'b0, 1'b0);
    exp_q.push_back('0);
    cyc();
    obs = sample(); e = exp_q.pop_front(); total++;
    if (obs !== e) $display("FAIL branch_idle got %h expected %h", obs, e);
    else passed++;
  endtask

  task automatic test_undefined();
    out_t obs, e;
    logic [31:0] ti [4];
    out_t        te [4];
    ti = '{ins(4'h1, 4'd3, 4'd1, 4'd2, 16'h0),
           ins(4'hC, 4'd3, 4'd3, 4'd3, 16'hFFFF),
           ins(4'h2, 4'd4, 4'd3, 4'd3, 16'h0),
           32'h0};
    te = '{mk(C_ADD | C_RW, 16'd5, 16'd7, 16'd3, 3'b000),
           '0,
           mk(C_SUB | C_RW, 16'h103, 16'h103, 16'd4, 3'b000),
           '0};
    for (int i = 0; i < 4; i++) begin
      drive(ti[i], (i < 3), 1'b0);
      exp_q.push_back(te[i]);
      cyc();
      obs = sample();
      e = exp_q.pop_front();
      total++;
      if (obs !== e) $display("FAIL undefined[%0d] got %h expected %h", i, obs, e);
      else passed++;
    end
  endtask

  task automatic test_halt();
    out_t obs, e;
    drive(ins(4'hF, 4'd0, 4'd0, 4'd0, 16'h0), 1'b1, 1'b0);
    exp_q.push_back(mk(C_HALT, 16'd0, 16'd0, 16'd0, 3'b000));
    cyc();
    obs = sample(); e = exp_q.pop_front(); total++;
    if (obs !== e) $display("FAIL halt_issue got %h expected %h", obs, e);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      drive(ins(4'h1, 4'd3, 4'd1, 4'd2, 16'h0), 1'b1, 1'b0);
      #1;
      total++;
      if (fetch.inst_ready !== 1'b0) $display("FAIL halted_ready[%0d] got %b expected 0", i, fetch.inst_ready);
      else passed++;
      exp_q.push_back(mk(C_HALT, 16'd0, 16'd0, 16'd0, 3'b000));
      cyc();
      obs = sample(); e = exp_q.pop_front(); total++;
      if (obs !== e) $display("FAIL halted_hold[%0d] got %h expected %h", i, obs, e);
      else passed++;
    end
    rst = 1'b0;
    drive(32'h0, 1'b0, 1'b0);
    #1;
    obs = sample(); total++;
    if (obs !== '0) $display("FAIL halt_reset_outputs got %h expected 0", obs);
    else passed++;
    cyc();
    rst = 1'b1;
    #1;
    total++;
    if (fetch.inst_ready !== 1'b1) $display("FAIL halt_reset_ready got %b expected 1", fetch.inst_ready);
    else passed++;
    drive(ins(4'h1, 4'd3, 4'd1, 4'd2, 16'h0), 1'b1, 1'b0);
    exp_q.push_back(mk(C_ADD | C_RW, 16'd5, 16'd7, 16'd3, 3'b000));
    cyc();
    obs = sample(); e = exp_q.pop_front(); total++;
    if (obs !== e) $display("FAIL post_halt_add got %h expected %h", obs, e);
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 16'h0100 + 16'(i);
    rf[1] = 16'd5;
    rf[2] = 16'd7;
    test_reset();
    test_add();
    test_hazard();
    test_store_stall();
    test_branch();
    test_undefined();
    test_halt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/decode_issue.md
# decode_issue

- Decode/issue stage of the pipelined core; sits between instruction fetch and the execute stage.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake and reads the register file.
- Registers the one-hot ALU controls, operands and the destination/target for execute, plus forwarding-hazard flags against the previously issued instruction.
- Handles branch squash, store-data stalls and halt.

## Interface
Parameters:
- WORD_W, 16, datapath word width (val1/val2/val3)
- REG_N, 16, register count (4-bit register addresses)

Ports (clock and reset first):
- Reset is asynchronous and active-low.
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- inst  in  32  instruction: [31:28] opcode, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] imm
- inst_valid  in  1  fetch presents inst
- inst_ready  out  1  decode accepts inst this cycle
- rf_raddr1 / rf_raddr2 / rf_raddr3  out  4 each  combinational read addresses: rs1, rs2, rd
- rf_rdata1 / rf_rdata2 / rf_rdata3  in  WORD_W each  register file read data, same cycle
- do_branch  in  1  execute reports taken branch
- is_add, is_sub, is_and, is_or, is_gt, is_eq  out  1 each  one-hot ALU select
- is_mem_write, is_reg_write, is_halt, is_branch  out  1 each  control
- val1, val2, val3  out  WORD_W each  operands / destination-or-target
- is_val1_data_hazard, is_val2_data_hazard, is_mem_data_hazard  out  1 each  forwarding selects

## Operation
Opcodes:
- 0 NOP
- 1 ADD, 2 SUB, 3 AND, 4 OR, 5 GT, 6 EQ: val1=R[rs1], val2=R[rs2], val3=rd, is_reg_write=1
- 7 ADDI: is_add, val2=sign-extended imm, val3=rd, is_reg_write=1
- 8 LOAD: is_add, val1=R[rs1], val2=imm, val3=rd, is_reg_write=1; marks result as memory-sourced
- 9 STORE: is_add, address R[rs1]+imm, val3=R[rd], is_mem_write=1
- A BEQ / B BGT: is_eq / is_gt on R[rs1], R[rs2]; is_branch=1; val3=imm target
- F HALT: is_halt=1
- Any other opcode decodes as NOP.

Tracking registers, updated on every issue including bubbles:
- prev_dst (4b), prev_wr, prev_load.
- A bubble or NOP clears prev_wr and prev_load.

Hazard flags, registered with the instruction:
- val1 hazard = prev_wr && rs1==prev_dst, only for ops that read rs1.
- val2 hazard = same test on rs2, only for R-type and branch ops.
- is_mem_data_hazard = prev_load && (either val hazard).
- Immediates never hazard.
- Register file is write-through. Only the immediately preceding instruction is checked.

State machine, states RUN / STALL / HALTED:
- RUN: inst_ready = !do_branch.
  - STORE with prev_wr && rd==prev_dst: issue a bubble, stay un-accepted (inst_ready=0), go to STALL.
  - HALT accepted: go to HALTED.
- STALL: one cycle. prev_wr is now 0, so the store issues normally; return to RUN.
- HALTED: inst_ready=0. Outputs are NOP with is_halt held at 1. Only reset exits.

Branch squash:
- While do_branch=1, is_reg_write, is_mem_write, is_branch and is_halt outputs are forced to 0 combinationally, killing the wrong-path instruction execute is sampling.
- At the next edge the output register loads a bubble and prev_wr/prev_load are cleared.
- Branch beats stall: in STALL with do_branch, go to RUN and drop the pending store (fetch redirects).
- Branch beats halt accept: an instruction presented during do_branch is never accepted.

## Timing
- Reset: inst_ready=0 while rst low, then 1.
- Reset: every is_* output, all hazard flags, val1/val2/val3 and tracking registers are 0.
- Reset: state is RUN.
- Latency: inst accepted on edge k (inst_valid && inst_ready) → decoded outputs valid from edge k to edge k+1.
- Register file is read in the same cycle as acceptance.
- No valid input in RUN → bubble issued.
- Store-after-write stall costs exactly one bubble.
- Branch squash costs one bubble plus the combinationally killed instruction.
- Reset asserted mid-stall or in HALTED returns to RUN with reset values immediately; no issue occurs on the first edge after release unless inst_valid.

## Test plan
- ADD r3,r1,r2 with R1=5, R2=7 → next cycle is_add=1, val1=5, val2=7, val3=3, is_reg_write=1, no hazards.
- ADD r3,.. then SUB r4,r3,r3 → SUB issues with is_val1_data_hazard=1, is_val2_data_hazard=1, is_mem_data_hazard=0. Repeat with LOAD r3 first → is_mem_data_hazard=1.
- ADDI r5,.. then STORE rd=r5 → one bubble (all is_*=0, inst_ready=0 one cycle), then the store issues with is_mem_write=1 and no stall repeat.
- BEQ issued, do_branch pulsed with ADD behind it → is_reg_write low during the pulse, the next cycle is a bubble, and the next ADD after redirect shows no hazard against the pre-branch instruction.
- HALT → is_halt=1 and held, inst_ready=0 forever. Reset mid-halt → all outputs 0, inst_ready=1 after release.
- Undefined opcode 0xC with inst_valid → bubble-equivalent outputs, prev_wr cleared.
